tick_scheduler: RTL

//  Multi-channel clock-enable generator and divisor controller. Derives NUM_CH independent
//  one-cycle tick pulses from the single system clock, each with a run-time programmable

---
 rtl/tick_scheduler.sv | 130 +++++++++++++
 1 files changed

// File: rtl/tick_scheduler.sv
// Multi-channel tick (clock-enable) generator with per-channel programmable divisors.
// Divisor updates go through a valid/ready request and land only on a period boundary.
module tick_scheduler #(
    parameter int RAW_CLOCK_FREQ = 100_000_000,
    parameter int NUM_CH         = 4,
    parameter int DIV_WIDTH      = 16,
    parameter int DEFAULT_DIV    = RAW_CLOCK_FREQ / 1_000_000,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    ch_en,
    input  logic                 sync_start,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    output logic                 cfg_done,
    output logic [NUM_CH-1:0]    tick,
    output logic [1:0]           dbg_state_o
);
    // Handshake: an update is accepted on any rising edge where cfg_valid and cfg_ready
    // are both high; the requester holds cfg_valid and its payload until then.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        DONE    = 2'd2
    } cfg_state_e;

    cfg_state_e           state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q [NUM_CH];
    logic [DIV_WIDTH-1:0] cnt_d [NUM_CH];
    logic [DIV_WIDTH-1:0] div_q [NUM_CH];
    logic [DIV_WIDTH-1:0] div_d [NUM_CH];
    logic [NUM_CH-1:0]    tick_q, tick_d;
    logic [NUM_CH-1:0]    wrap;
    logic [CH_W-1:0]      sh_ch_q, sh_ch_d;
    logic [DIV_WIDTH-1:0] sh_div_q, sh_div_d;
    logic                 ch_ok;
    logic                 apply;

    // Out-of-range channel numbers only exist when NUM_CH is not a power of two.
    generate
        if ((1 << CH_W) == NUM_CH) begin : g_full_range
            assign ch_ok = 1'b1;
        end else begin : g_part_range
            assign ch_ok = (int'(cfg_ch) < NUM_CH);
        end
    endgenerate

    always_comb begin
        wrap = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wrap[i] = ch_en[i] && (div_q[i] != '0) && (cnt_q[i] == div_q[i] - DIV_WIDTH'(1));
        end
    end

    assign apply = (state_q == PENDING) &&
                   (wrap[sh_ch_q] || !ch_en[sh_ch_q] || (div_q[sh_ch_q] == '0) || sync_start);

    always_comb begin
        state_d  = state_q;
        sh_ch_d  = sh_ch_q;
        sh_div_d = sh_div_q;
        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    if (ch_ok) begin
                        sh_ch_d  = cfg_ch;
                        sh_div_d = cfg_div;
                        state_d  = PENDING;
                    end else begin
                        state_d  = DONE;
                    end
                end
            end
            PENDING: if (apply) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A wrap that coincides with the apply edge still emits its tick, so no period is lost.
    always_comb begin
        tick_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            div_d[i] = div_q[i];
            if (!ch_en[i] || (div_q[i] == '0) || sync_start) begin
                cnt_d[i] = '0;
            end else if (wrap[i]) begin
                cnt_d[i]  = '0;
                tick_d[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + DIV_WIDTH'(1);
            end
            if (apply && (sh_ch_q == CH_W'(i))) begin
                div_d[i] = sh_div_q;
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sh_ch_q  <= '0;
            sh_div_q <= '0;
            tick_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
                div_q[i] <= DIV_WIDTH'(DEFAULT_DIV);
            end
        end else begin
            state_q  <= state_d;
            sh_ch_q  <= sh_ch_d;
            sh_div_q <= sh_div_d;
            tick_q   <= tick_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                div_q[i] <= div_d[i];
            end
        end
    end

    assign tick        = tick_q;
    assign cfg_ready   = (state_q == IDLE);
    assign cfg_done    = (state_q == DONE);
    assign dbg_state_o = state_q;

endmodule
